// File: rtl/fx_writeback_stage.sv
// FX writeback stage: buffers up to two results per bundle and drains them to the
// single-port GPR file and the special-register port, splitting same-port pairs.
module fx_writeback_stage #(
  parameter int DEPTH       = 4,
  parameter int FXUnitCode  = 0,
  parameter int STALL_LEVEL = DEPTH - 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [1:0]  functionalUnitCode_i,
  input  logic        reg1WritebackEnable_i,
  input  logic        reg2WritebackEnable_i,
  input  logic [5:0]  reg1WritebackAddress_i,
  input  logic [5:0]  reg2WritebackAddress_i,
  input  logic [63:0] reg1WritebackVal_i,
  input  logic [63:0] reg2WritebackVal_i,
  output logic        gprWriteEnable_o,
  output logic [4:0]  gprWriteAddress_o,
  output logic [63:0] gprWriteVal_o,
  output logic        sprWriteEnable_o,
  output logic [4:0]  sprWriteAddress_o,
  output logic [63:0] sprWriteVal_o,
  output logic        stall_o,
  output logic        overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW+1)'(STALL_LEVEL);

  typedef struct packed {
    logic        en1;
    logic        en2;
    logic [5:0]  a1;
    logic [5:0]  a2;
    logic [63:0] v1;
    logic [63:0] v2;
  } wb_t;

  typedef enum logic {ONE, SECOND} st_t;

  wb_t           mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;
  st_t           state, state_nxt;

  wb_t  head;
  logic head_vld, same_port, issue1, issue2, retire, push_req, push;
  logic        g_we, s_we;
  logic [4:0]  g_a, s_a;
  logic [63:0] g_v, s_v;

  assign head      = mem[rd_ptr];
  assign head_vld  = (count != '0);
  // Address bit 5 picks the port: 0-31 GPR, 32-63 special; bits 4:0 are the index.
  assign same_port = head.en1 & head.en2 & (head.a1[5] == head.a2[5]);
  assign push_req  = (functionalUnitCode_i == 2'(FXUnitCode)) &
                     (reg1WritebackEnable_i | reg2WritebackEnable_i);
  assign push      = push_req & ((count != FULL_CNT) | retire);

  always_comb begin
    state_nxt = state;
    issue1    = 1'b0;
    issue2    = 1'b0;
    retire    = 1'b0;
    case (state)
      ONE: if (head_vld) begin
        issue1 = head.en1;
        if (same_port) begin
          state_nxt = SECOND;
        end else begin
          issue2 = head.en2;
          retire = 1'b1;
        end
      end
      SECOND: begin
        issue2    = 1'b1;
        retire    = 1'b1;
        state_nxt = ONE;
      end
      default: state_nxt = ONE;
    endcase
  end

  // Issued writes never collide on a port; unused ports hold their last addr/data.
  always_comb begin
    g_we = 1'b0; g_a = gprWriteAddress_o; g_v = gprWriteVal_o;
    s_we = 1'b0; s_a = sprWriteAddress_o; s_v = sprWriteVal_o;
    if (issue1) begin
      if (head.a1[5]) begin s_we = 1'b1; s_a = head.a1[4:0]; s_v = head.v1; end
      else            begin g_we = 1'b1; g_a = head.a1[4:0]; g_v = head.v1; end
    end
    if (issue2) begin
      if (head.a2[5]) begin s_we = 1'b1; s_a = head.a2[4:0]; s_v = head.v2; end
      else            begin g_we = 1'b1; g_a = head.a2[4:0]; g_v = head.v2; end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, retire})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) mem[wr_ptr] <= '{en1: reg1WritebackEnable_i, en2: reg2WritebackEnable_i,
                                a1: reg1WritebackAddress_i, a2: reg2WritebackAddress_i,
                                v1: reg1WritebackVal_i, v2: reg2WritebackVal_i};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state             <= ONE;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      gprWriteEnable_o  <= 1'b0;
      gprWriteAddress_o <= '0;
      gprWriteVal_o     <= '0;
      sprWriteEnable_o  <= 1'b0;
      sprWriteAddress_o <= '0;
      sprWriteVal_o     <= '0;
      stall_o           <= 1'b0;
      overflow_o        <= 1'b0;
    end else begin
      state             <= state_nxt;
      count             <= count_nxt;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      gprWriteEnable_o  <= g_we;
      gprWriteAddress_o <= g_a;
      gprWriteVal_o     <= g_v;
      sprWriteEnable_o  <= s_we;
      sprWriteAddress_o <= s_a;
      sprWriteVal_o     <= s_v;
      stall_o           <= (count_nxt >= STALL_CNT);
      if (push_req && !push) overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fx_writeback_stage.sv
// Randomized bench for fx_writeback_stage against a bundle-queue reference model.
module tb_fx_writeback_stage;
  localparam int DEPTH = 4;
  localparam int STALL_LEVEL = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fu;
  logic        e1, e2;
  logic [5:0]  a1, a2;
  logic [63:0] v1, v2;
  logic        gpr_we, spr_we, stall, ovf;
  logic [4:0]  gpr_a, spr_a;
  logic [63:0] gpr_v, spr_v;

  always #5 clk = ~clk;

  fx_writeback_stage #(.DEPTH(DEPTH), .FXUnitCode(0), .STALL_LEVEL(STALL_LEVEL)) dut (
    .clock_i(clk), .reset_i(rst), .functionalUnitCode_i(fu),
    .reg1WritebackEnable_i(e1), .reg2WritebackEnable_i(e2),
    .reg1WritebackAddress_i(a1), .reg2WritebackAddress_i(a2),
    .reg1WritebackVal_i(v1), .reg2WritebackVal_i(v2),
    .gprWriteEnable_o(gpr_we), .gprWriteAddress_o(gpr_a), .gprWriteVal_o(gpr_v),
    .sprWriteEnable_o(spr_we), .sprWriteAddress_o(spr_a), .sprWriteVal_o(spr_v),
    .stall_o(stall), .overflow_o(ovf));

  typedef struct {
    logic e1, e2; logic [5:0] a1, a2; logic [63:0] v1, v2;
  } bundle_t;

  bundle_t q[$];
  bit      half_done;
  logic        x_gwe, x_swe, x_stall, x_ovf;
  logic [4:0]  x_ga, x_sa;
  logic [63:0] x_gv, x_sv;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // One result landing on whichever port its address selects.
  task automatic emit(input logic [5:0] a, input logic [63:0] v);
    if (a >= 6'd32) begin x_swe = 1'b1; x_sa = a - 6'd32; x_sv = v; end
    else            begin x_gwe = 1'b1; x_ga = a[4:0];    x_sv = x_sv; x_gv = v; end
  endtask

  task automatic model();
    bit popped = 0;
    int size_before = q.size();
    bundle_t b;
    if (rst) begin
      q.delete(); half_done = 0;
      x_gwe = 0; x_swe = 0; x_ga = 0; x_sa = 0; x_gv = 0; x_sv = 0;
      x_stall = 0; x_ovf = 0;
      return;
    end
    x_gwe = 0; x_swe = 0;
    if (q.size() > 0) begin
      b = q[0];
      if (half_done) begin
        emit(b.a2, b.v2); popped = 1; half_done = 0;
      end else if (b.e1 && b.e2 && ((b.a1 >= 6'd32) == (b.a2 >= 6'd32))) begin
        emit(b.a1, b.v1); half_done = 1;
      end else begin
        if (b.e1) emit(b.a1, b.v1);
        if (b.e2) emit(b.a2, b.v2);
        popped = 1;
      end
      if (popped) void'(q.pop_front());
    end
    if (fu == 2'd0 && (e1 || e2)) begin
      if (size_before < DEPTH || popped)
        q.push_back('{e1: e1, e2: e2, a1: a1, a2: a2, v1: v1, v2: v2});
      else x_ovf = 1;
    end
    x_stall = (q.size() >= STALL_LEVEL);
  endtask

  task automatic step(input logic r, input logic [1:0] f,
                      input logic en1, input logic [5:0] ad1, input logic [63:0] d1,
                      input logic en2, input logic [5:0] ad2, input logic [63:0] d2);
    rst = r; fu = f; e1 = en1; a1 = ad1; v1 = d1; e2 = en2; a2 = ad2; v2 = d2;
    @(posedge clk);
    model();
    #1;
    chk("gpr_we", 64'(gpr_we), 64'(x_gwe));
    chk("spr_we", 64'(spr_we), 64'(x_swe));
    chk("gpr_a", 64'(gpr_a), 64'(x_ga));
    chk("gpr_v", gpr_v, x_gv);
    chk("spr_a", 64'(spr_a), 64'(x_sa));
    chk("spr_v", spr_v, x_sv);
    chk("stall", 64'(stall), 64'(x_stall));
    chk("overflow", 64'(ovf), 64'(x_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'd0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
  endtask

  initial begin
    half_done = 0;
    // Reset held: everything reads zero.
    for (int i = 0; i < 3; i++) step(1, 2'd0, 1, 6'd9, 64'hdead, 1, 6'd40, 64'hbeef);
    // Single push, GPR r3.
    step(0, 2'd0, 1, 6'd3, 64'h1234, 0, 6'd0, 64'd0);
    step(0, 2'd0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
    chk("single_gpr", {gpr_we, 3'b0, gpr_a, gpr_v[15:0]}, {1'b1, 3'b0, 5'd3, 16'h1234});
    idle(1);
    chk("single_idle", 64'({gpr_we, spr_we}), 64'd0);
    // Split bundle: GPR r5 and SPR idx 0 in one cycle.
    step(0, 2'd0, 1, 6'd5, 64'hA, 1, 6'd32, 64'h1);
    idle(1);
    chk("split_both", 64'({gpr_we, spr_we}), 64'b11);
    idle(1);
    // Same-port pair r7: 0x11 then 0x22.
    step(0, 2'd0, 1, 6'd7, 64'h11, 1, 6'd7, 64'h22);
    idle(1);
    chk("pair_first", gpr_v, 64'h11);
    idle(1);
    chk("pair_final", gpr_v, 64'h22);
    chk("pair_no_spr", 64'(spr_we), 64'd0);
    idle(1);
    // Back-to-back same-port pairs: stall, overflow and wrap-order.
    for (int i = 0; i < 8; i++)
      step(0, 2'd0, 1, 6'(i), 64'(100 + i), 1, 6'(i + 8), 64'(200 + i));
    chk("overflow_set", 64'(ovf), 64'd1);
    idle(20);
    // Foreign unit and empty bundles are ignored.
    step(0, 2'd1, 1, 6'd4, 64'h55, 1, 6'd36, 64'h66);
    step(0, 2'd0, 0, 6'd4, 64'h55, 0, 6'd36, 64'h66);
    idle(2);
    // Reset while mid-drain with entries queued.
    for (int i = 0; i < 4; i++)
      step(0, 2'd0, 1, 6'd40 + 6'(i), 64'(i), 1, 6'd50, 64'(i + 9));
    step(1, 2'd0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    idle(2);
    step(0, 2'd0, 1, 6'd12, 64'h777, 0, 6'd0, 64'd0);
    idle(1);
    chk("post_rst_push", {59'(gpr_we), gpr_a}, {59'd1, 5'd12});
    // Randomized traffic with pressure bursts.
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] r1 = 6'($urandom_range(0, 63));
      logic [5:0] r2 = ($urandom_range(0, 3) == 0) ? r1 : 6'($urandom_range(0, 63));
      logic [1:0] f = ($urandom_range(0, 9) < 8) ? 2'd0 : 2'($urandom_range(1, 3));
      logic       r = ($urandom_range(0, 199) == 0);
      step(r, f, 1'($urandom), r1, {$urandom, $urandom},
           1'($urandom), r2, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 4));
    end
    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
